// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: FSM states, I/O page
// offsets and the default I/O page base address.
package mips_mem_responder_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [7:0]  OFF_CYCLES      = 8'h00;
    localparam logic [7:0]  OFF_LEDS        = 8'h04;
    localparam logic [7:0]  OFF_STATUS      = 8'h08;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

endpackage

// File: rtl/mips_mem_ram.sv
// Unified instruction/data word RAM: synchronous write, asynchronous read.
// The write port is shared between the program loader and the CPU through
// a 2:1 mux; the two enables are never active together because the loader
// only writes in LOAD and the CPU only writes in RUN.
module mips_mem_ram #(
  parameter int unsigned MEM_WORDS = 64,
  parameter string       INIT_FILE = "",
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_data,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0]   mem [MEM_WORDS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  // Write-port mux: loader has the port whenever it is writing.
  always_comb begin
    we    = ld_we | cpu_we;
    waddr = ld_we ? ld_addr : cpu_addr;
    wdata = ld_we ? ld_data : cpu_data;
  end

  // Synchronous word write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS bus. Holds the program
// loader FSM (which keeps the CPU in reset while loading), the address
// decode, the I/O register page (CYCLES, LEDS, STATUS) and the RAM.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT,
    parameter bit          BOOT_RUN  = 1'b0,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic [7:0]  leds,
    output logic        bus_err
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [AW-1:0] LAST_PTR = AW'(MEM_WORDS - 1);
    localparam state_t      RST_STATE = BOOT_RUN ? RUN : HOLD;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [31:0]   cycles;
    logic [31:0]   ram_rdata;

    logic          io_sel;
    logic          ram_sel;
    logic          misaligned;
    logic [7:0]    io_off;
    logic          cpu_store;
    logic          err_set;
    logic          io_we;
    logic          status_clr;
    logic          ram_we;
    logic          ld_xfer;
    logic          ld_done;

    // Address decode and store qualification.
    always_comb begin
        io_sel     = (adr[31:8] == IO_BASE[31:8]);
        ram_sel    = (adr < RAM_BYTES);
        misaligned = (adr[1:0] != 2'b00);
        io_off     = {adr[7:2], 2'b00};
        cpu_store  = (state == RUN) && memwrite;
        err_set    = cpu_store && (misaligned || !(io_sel || ram_sel));
        io_we      = cpu_store && io_sel && !misaligned;
        // The clear ignores alignment so a misaligned STATUS store raises
        // the error and requests a clear in the same cycle; set wins below.
        status_clr = cpu_store && io_sel && (io_off == OFF_STATUS) && writedata[0];
        ram_we     = cpu_store && ram_sel && !io_sel && !misaligned;
        ld_xfer    = ld_valid && ld_ready;
        ld_done    = ld_xfer && (ld_last || (ptr == LAST_PTR));
    end

    // Loader FSM with registered ld_ready/cpu_reset and the RUN cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RST_STATE;
            ptr       <= '0;
            cycles    <= '0;
            ld_ready  <= 1'b0;
            cpu_reset <= !BOOT_RUN;
        end else begin
            case (state)
                HOLD: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_xfer) begin
                        ptr <= ptr + 1'b1;
                        if (ld_done) begin
                            state     <= RUN;
                            ld_ready  <= 1'b0;
                            cpu_reset <= 1'b0;
                            cycles    <= '0;
                        end
                    end
                end
                RUN: begin
                    cycles <= cycles + 32'd1;
                    if (ld_start) begin
                        state     <= LOAD;
                        ptr       <= '0;
                        ld_ready  <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= HOLD;
                    ld_ready  <= 1'b0;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    // I/O registers: LED latch and sticky bus error (set beats clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds    <= '0;
            bus_err <= 1'b0;
        end else begin
            if (io_we && (io_off == OFF_LEDS)) begin
                leds <= writedata[7:0];
            end
            if (err_set) begin
                bus_err <= 1'b1;
            end else if (status_clr) begin
                bus_err <= 1'b0;
            end
        end
    end

    // Read mux: I/O page first, then RAM, otherwise zero.
    always_comb begin
        readdata = '0;
        if (io_sel) begin
            case (io_off)
                OFF_CYCLES: readdata = cycles;
                OFF_LEDS:   readdata = {24'b0, leds};
                OFF_STATUS: readdata = {31'b0, bus_err};
                default:    readdata = '0;
            endcase
        end else if (ram_sel) begin
            readdata = ram_rdata;
        end
    end

    mips_mem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .INIT_FILE (INIT_FILE),
        .AW        (AW)
    ) u_ram (
        .clk      (clk),
        .ld_we    (ld_xfer),
        .ld_addr  (ptr),
        .ld_data  (ld_data),
        .cpu_we   (ram_we),
        .cpu_addr (adr[AW+1:2]),
        .cpu_data (writedata),
        .raddr    (adr[AW+1:2]),
        .rdata    (ram_rdata)
    );

endmodule
